// File: rtl/timer_avalon_32to16_adapter.sv
// 32-bit Avalon-MM slave to 16-bit timer port adapter.
// Ports: clk/reset_n; s_* upstream 32-bit slave; m_* downstream 16-bit timer port.
module timer_avalon_32to16_adapter #(
  parameter int S_ADDR_W = 2
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [S_ADDR_W-1:0] s_address,
  input  logic                s_read,
  input  logic                s_write,
  input  logic [3:0]          s_byteenable,
  input  logic [31:0]         s_writedata,
  output logic [31:0]         s_readdata,
  output logic                s_waitrequest,
  output logic                m_chipselect,
  output logic                m_write_n,
  output logic [S_ADDR_W:0]   m_address,
  output logic [15:0]         m_writedata,
  input  logic [15:0]         m_readdata
);

  typedef enum logic [2:0] {
    IDLE, LO, HI, CAP, DONE
  } state_t;

  state_t              state_q, state_d;
  logic                wr_q, wr_d;
  logic                en_lo_q, en_lo_d;
  logic                en_hi_q, en_hi_d;
  logic [S_ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]         wdata_q, wdata_d;
  logic                rd_lo_q, rd_lo_d;
  logic                rd_hi_q, rd_hi_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                cs_q, cs_d;
  logic                wn_q, wn_d;
  logic [S_ADDR_W:0]   maddr_q, maddr_d;
  logic [15:0]         mwdata_q, mwdata_d;

  logic                req;
  logic                start;
  logic                cur_wr;
  logic                cur_lo;
  logic                cur_hi;
  logic [S_ADDR_W-1:0] cur_addr;
  logic [31:0]         cur_wdata;

  always_comb begin
    req   = s_read | s_write;
    start = (state_q == IDLE) && req;

    // The first access is issued from the IDLE cycle, so it must
    // use the live request rather than the latched copy.
    cur_wr    = start ? s_write : wr_q;
    cur_lo    = start ? |s_byteenable[1:0] : en_lo_q;
    cur_hi    = start ? |s_byteenable[3:2] : en_hi_q;
    cur_addr  = start ? s_address : addr_q;
    cur_wdata = start ? s_writedata : wdata_q;

    state_d  = state_q;
    wr_d     = wr_q;
    en_lo_d  = en_lo_q;
    en_hi_d  = en_hi_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_lo_d  = 1'b0;
    rd_hi_d  = 1'b0;
    rdata_d  = rdata_q;
    cs_d     = 1'b0;
    wn_d     = 1'b1;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;

    if (start) begin
      wr_d    = cur_wr;
      en_lo_d = cur_lo;
      en_hi_d = cur_hi;
      addr_d  = cur_addr;
      wdata_d = cur_wdata;
      if (!s_write) rdata_d = '0;
    end

    // Timer readdata is registered: it belongs to last cycle's access.
    if (rd_lo_q) rdata_d[15:0]  = m_readdata;
    if (rd_hi_q) rdata_d[31:16] = m_readdata;

    unique case (state_q)
      IDLE: begin
        if (req) begin
          if (cur_lo)      state_d = LO;
          else if (cur_hi) state_d = HI;
          else             state_d = DONE;
        end
      end
      LO: begin
        rd_lo_d = !wr_q;
        if (en_hi_q)   state_d = HI;
        else if (wr_q) state_d = DONE;
        else           state_d = CAP;
      end
      HI: begin
        rd_hi_d = !wr_q;
        state_d = wr_q ? DONE : CAP;
      end
      CAP:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Downstream strobes exist only while in LO or HI.
    if (state_d == LO) begin
      cs_d     = 1'b1;
      wn_d     = !cur_wr;
      maddr_d  = {cur_addr, 1'b0};
      mwdata_d = cur_wdata[15:0];
    end else if (state_d == HI) begin
      cs_d     = 1'b1;
      wn_d     = !cur_wr;
      maddr_d  = {cur_addr, 1'b1};
      mwdata_d = cur_wdata[31:16];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      en_lo_q  <= 1'b0;
      en_hi_q  <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_lo_q  <= 1'b0;
      rd_hi_q  <= 1'b0;
      rdata_q  <= '0;
      cs_q     <= 1'b0;
      wn_q     <= 1'b1;
      maddr_q  <= '0;
      mwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      en_lo_q  <= en_lo_d;
      en_hi_q  <= en_hi_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_lo_q  <= rd_lo_d;
      rd_hi_q  <= rd_hi_d;
      rdata_q  <= rdata_d;
      cs_q     <= cs_d;
      wn_q     <= wn_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
    end
  end

  assign s_readdata    = rdata_q;
  assign s_waitrequest = req & (state_q != DONE);
  assign m_chipselect  = cs_q;
  assign m_write_n     = wn_q;
  assign m_address     = maddr_q;
  assign m_writedata   = mwdata_q;

endmodule

// File: tb/tb_timer_avalon_32to16_adapter.sv
// Self-checking bench for timer_avalon_32to16_adapter.
// Random and directed Avalon transactions against a word-level model.
module tb_timer_avalon_32to16_adapter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [1:0]  s_address = '0;
  logic        s_read = 1'b0;
  logic        s_write = 1'b0;
  logic [3:0]  s_byteenable = '0;
  logic [31:0] s_writedata = '0;
  logic [31:0] s_readdata;
  logic        s_waitrequest;
  logic        m_chipselect;
  logic        m_write_n;
  logic [2:0]  m_address;
  logic [15:0] m_writedata;
  logic [15:0] m_readdata = '0;

  int errs = 0;
  int checks = 0;

  logic [15:0] dmem [8];
  logic [15:0] ref_mem [8];

  timer_avalon_32to16_adapter #(.S_ADDR_W(2)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s_address(s_address),
    .s_read(s_read),
    .s_write(s_write),
    .s_byteenable(s_byteenable),
    .s_writedata(s_writedata),
    .s_readdata(s_readdata),
    .s_waitrequest(s_waitrequest),
    .m_chipselect(m_chipselect),
    .m_write_n(m_write_n),
    .m_address(m_address),
    .m_writedata(m_writedata),
    .m_readdata(m_readdata)
  );

  always #5 clk = ~clk;

  // Timer slave: registered readdata, one clk after the address cycle.
  always @(posedge clk) begin
    if (m_chipselect) begin
      if (!m_write_n) dmem[m_address] <= m_writedata;
      else            m_readdata <= dmem[m_address];
    end
  end

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [47:0] pk(input int c, input bit we,
                                     input logic [2:0] ad,
                                     input logic [15:0] d);
    return {8'(c), 7'd0, we, 13'd0, ad, d};
  endfunction

  task automatic xact(input bit wr_req, input bit rd_req,
                      input logic [1:0] a, input logic [3:0] be,
                      input logic [31:0] wd);
    logic [47:0] exp_q [$];
    logic [47:0] got_q [$];
    bit          wr;
    bit          elo;
    bit          ehi;
    int          c;
    int          exp_tot;
    int          cyc;
    logic [31:0] exp_rd;
    wr  = wr_req;
    elo = (be[1:0] != 0);
    ehi = (be[3:2] != 0);
    exp_rd = {ehi ? ref_mem[{a, 1'b1}] : 16'h0,
              elo ? ref_mem[{a, 1'b0}] : 16'h0};
    c = 1;
    if (elo) begin
      exp_q.push_back(pk(c, wr, {a, 1'b0}, wr ? wd[15:0] : 16'h0));
      c++;
    end
    if (ehi) begin
      exp_q.push_back(pk(c, wr, {a, 1'b1}, wr ? wd[31:16] : 16'h0));
      c++;
    end
    exp_tot = c + 1 + ((!wr && (elo || ehi)) ? 1 : 0);
    if (wr) begin
      if (elo) ref_mem[{a, 1'b0}] = wd[15:0];
      if (ehi) ref_mem[{a, 1'b1}] = wd[31:16];
    end

    @(negedge clk);
    s_address    = a;
    s_read       = rd_req;
    s_write      = wr_req;
    s_byteenable = be;
    s_writedata  = wd;
    #1;
    chk("wait_c0", 64'(s_waitrequest), 64'd1);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
      if (m_chipselect)
        got_q.push_back(pk(cyc, !m_write_n, m_address,
                           m_write_n ? 16'h0 : m_writedata));
    end while (s_waitrequest && cyc < 20);
    chk("timeout", 64'(s_waitrequest), 64'd0);
    chk("latency", 64'(cyc + 1), 64'(exp_tot));
    chk("n_acc", 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk("acc", 64'(got_q[i]), 64'(exp_q[i]));
    if (!wr) chk("rdata", 64'(s_readdata), 64'(exp_rd));
    s_read  = 1'b0;
    s_write = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_cs", 64'(m_chipselect), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < 8; i++) begin
      dmem[i]    = 16'($urandom);
      ref_mem[i] = dmem[i];
    end
    dmem[4] = 16'h1234;
    ref_mem[4] = 16'h1234;
    dmem[5] = 16'hABCD;
    ref_mem[5] = 16'hABCD;

    #12;
    chk("rst_cs", 64'(m_chipselect), 64'd0);
    chk("rst_wn", 64'(m_write_n), 64'd1);
    chk("rst_addr", 64'(m_address), 64'd0);
    chk("rst_wdata", 64'(m_writedata), 64'd0);
    chk("rst_rdata", 64'(s_readdata), 64'd0);
    chk("rst_wait", 64'(s_waitrequest), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;

    xact(1'b1, 1'b0, 2'd1, 4'hF, 32'h0001_86A0);
    chk("mem2", 64'(dmem[2]), 64'h86A0);
    chk("mem3", 64'(dmem[3]), 64'h0001);
    xact(1'b0, 1'b1, 2'd2, 4'hF, 32'h0);
    chk("rd_word2", 64'(s_readdata), 64'hABCD_1234);
    xact(1'b0, 1'b1, 2'd0, 4'hC, 32'h0);
    xact(1'b1, 1'b0, 2'd3, 4'h0, 32'hDEAD_BEEF);
    xact(1'b0, 1'b1, 2'd3, 4'h0, 32'h0);
    xact(1'b1, 1'b1, 2'd0, 4'h3, 32'h5555_AAAA);

    // Reset while the low write is on the bus.
    @(negedge clk);
    s_address    = 2'd2;
    s_write      = 1'b1;
    s_byteenable = 4'hF;
    s_writedata  = 32'h7777_8888;
    @(posedge clk);
    #1;
    chk("pre_rst_cs", 64'(m_chipselect), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("arst_cs", 64'(m_chipselect), 64'd0);
    chk("arst_wn", 64'(m_write_n), 64'd1);
    chk("arst_addr", 64'(m_address), 64'd0);
    chk("arst_rdata", 64'(s_readdata), 64'd0);
    s_write = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("post_rst_cs", 64'(m_chipselect), 64'd0);
    end
    xact(1'b0, 1'b1, 2'd2, 4'hF, 32'h0);

    for (int n = 0; n < 60; n++) begin
      int op;
      op = int'($urandom_range(0, 3));
      xact(op == 1 || op == 2, op != 1,
           2'($urandom), 4'($urandom), $urandom);
    end
    for (int a = 0; a < 4; a++)
      xact(1'b0, 1'b1, 2'(a), 4'hF, 32'h0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
